// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states
// and the request legality rule.
package lsu_pkg;

  // RV32 load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // RV32 store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // A request is legal when funct3 names an access that exists for the
  // direction and the address is naturally aligned for that width.
  function automatic logic lsu_legal(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      LB:      ok = 1'b1;
      LH:      ok = ~addr_lo[0];
      LW:      ok = (addr_lo == 2'b00);
      LBU:     ok = ~we;
      LHU:     ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extractor: picks the addressed byte/half out of the
// bus word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] wb_dat_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for the addressed byte and half
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_s = wb_dat_i[7:0];
      2'd1:    byte_s = wb_dat_i[15:8];
      2'd2:    byte_s = wb_dat_i[23:16];
      2'd3:    byte_s = wb_dat_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = wb_dat_i[31:16];
    end else begin
      half_s = wb_dat_i[15:0];
    end
  end

  // Width/sign extension selected by funct3
  always_comb begin
    data_o = 32'h0000_0000;
    case (funct3_i)
      LB:      data_o = {{24{byte_s[7]}}, byte_s};
      LH:      data_o = {{16{half_s[15]}}, half_s};
      LW:      data_o = wb_dat_i;
      LBU:     data_o = {24'h00_0000, byte_s};
      LHU:     data_o = {16'h0000, half_s};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one request at a time, checks legality, runs a
// single Wishbone transaction with byte lanes and returns extended load data
// or an error. All outputs are registered or decoded from the state register.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [3:0]  req_sel_s;
  logic [31:0] req_dat_s;
  logic [31:0] load_data_s;

  lsu_load_align u_align (
    .wb_dat_i  (wb_dat_i),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .data_o    (load_data_s)
  );

  // Byte-lane enables and lane-replicated write data for the incoming request
  always_comb begin
    req_sel_s = 4'b1111;
    req_dat_s = 32'h0000_0000;
    if (req_we_i) begin
      case (req_funct3_i)
        SB: begin
          req_sel_s = 4'b0001 << req_addr_i[1:0];
          req_dat_s = {4{req_wdata_i[7:0]}};
        end
        SH: begin
          req_sel_s = 4'b0011 << {req_addr_i[1], 1'b0};
          req_dat_s = {2{req_wdata_i[15:0]}};
        end
        SW: begin
          req_sel_s = 4'b1111;
          req_dat_s = req_wdata_i;
        end
        default: begin
          req_sel_s = 4'b0000;
          req_dat_s = 32'h0000_0000;
        end
      endcase
    end else begin
      req_sel_s = 4'b1111;
      req_dat_s = 32'h0000_0000;
    end
  end

  // Next-state and registered-output logic; response fields default to a
  // cleared one-cycle pulse
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          funct3_d  = req_funct3_i;
          addr_lo_d = req_addr_i[1:0];
          if (lsu_legal(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
            state_d = ST_BUS;
            cnt_d   = 16'd0;
            cyc_d   = 1'b1;
            we_d    = req_we_i;
            adr_d   = {req_addr_i[31:2], 2'b00};
            sel_d   = req_sel_s;
            dat_d   = req_dat_s;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (wb_err_i) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
        end else if (wb_ack_i) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          if (we_q) begin
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            rsp_rdata_d = load_data_s;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      cnt_q       <= 16'd0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0000_0000;
      sel_q       <= 4'b0000;
      dat_q       <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a driver issues requests and pushes the
// expected bus plan and response; a bus responder and a response monitor
// check the DUT independently against an arithmetic reference model.
module tb_lsu_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;

  lsu_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 ack, 1 err, 2 ack+err, 3 no response (timeout), 4 reset abort, 5 unexpected
  typedef struct {
    int          kind;
    int          w;
    logic [31:0] rdata;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
  } plan_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc_cnt  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit we, input bit [2:0] f3, input bit [31:0] addr);
    int size;
    size = int'(f3[1:0]);
    if (size == 3) return 1'b0;
    if (f3[2] && (we || size == 2)) return 1'b0;
    return (addr % (32'd1 << size)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input bit [2:0] f3, input bit [31:0] addr,
                                         input bit [31:0] bus);
    int bytes;
    logic [63:0] mask, val;
    bytes = 1 << int'(f3[1:0]);
    mask  = (64'd1 << (8 * bytes)) - 64'd1;
    val   = ({32'd0, bus} >> (8 * (addr % 4))) & mask;
    if (!f3[2] && bytes < 4 && val[8*bytes-1]) val = val | ~mask;
    return val[31:0];
  endfunction

  function automatic logic [3:0] m_sel(input bit we, input bit [2:0] f3, input bit [31:0] addr);
    int bytes;
    if (!we) return 4'hF;
    bytes = 1 << int'(f3[1:0]);
    return 4'(((1 << bytes) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_dat(input bit [2:0] f3, input bit [31:0] wdata);
    int bytes;
    logic [31:0] r;
    bytes = 1 << int'(f3[1:0]);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % bytes) +: 8];
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wdata, input int kind, input int w,
                       input bit [31:0] rdata, input bit abort_it);
    bit    legal;
    plan_t p;
    exp_t  e;
    int    guard;
    legal = m_legal(we, f3, addr);
    if (legal) begin
      p.kind  = abort_it ? 4 : kind;
      p.w     = w;
      p.rdata = rdata;
      p.adr   = addr & 32'hFFFF_FFFC;
      p.sel   = m_sel(we, f3, addr);
      p.dat   = m_dat(f3, wdata);
      p.we    = we;
      plan_q.push_back(p);
    end
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wdata;
    guard = 0;
    while (req_ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      chk("handshake_wait", 32'd0, 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    e.err   = !legal || kind != 0;
    e.rdata = (e.err || we) ? 32'd0 : m_load(f3, addr, rdata);
    if (!legal)         e.cycle = cyc_cnt + 1;
    else if (kind == 3) e.cycle = cyc_cnt + 1 + TMO;
    else                e.cycle = cyc_cnt + 2 + w;
    if (!abort_it) exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  // ---------------- bus responder / bus checker ----------------
  plan_t cur;
  bit    active = 1'b0;
  int    nbus   = 0;
  initial begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      if (wb_cyc_o === 1'b1 && !active) begin
        if (plan_q.size() == 0) begin
          chk("unexpected_bus_cycle", 32'd1, 32'd0);
          cur.kind = 5; cur.w = 0; cur.rdata = 32'd0;
        end else begin
          cur = plan_q.pop_front();
        end
        active = 1'b1;
        nbus = 0;
      end
      if (active) begin
        if (wb_cyc_o === 1'b1) begin
          if (cur.kind != 5) begin
            chk("wb_stb", 32'(wb_stb_o), 32'd1);
            chk("ready_in_bus", 32'(req_ready_o), 32'd0);
            chk("wb_we", 32'(wb_we_o), 32'(cur.we));
            chk("wb_adr", wb_adr_o, cur.adr);
            chk("wb_sel", 32'(wb_sel_o), 32'(cur.sel));
            if (cur.we) chk("wb_dat", wb_dat_o, cur.dat);
          end
          wb_dat_i = cur.rdata;
          if (nbus == cur.w) begin
            if (cur.kind == 0 || cur.kind == 2) wb_ack_i = 1'b1;
            if (cur.kind == 1 || cur.kind == 2) wb_err_i = 1'b1;
          end
          nbus++;
        end else begin
          if (cur.kind <= 3)
            chk("bus_cycle_len", 32'(nbus), 32'((cur.kind == 3) ? TMO : cur.w + 1));
          if (cur.kind == 3) wb_ack_i = 1'b1;  // late ack while in RESP
          active = 1'b0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_cycle", 32'(cyc_cnt), 32'(e.cycle));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit       we;
    bit [2:0] f3;
    bit [31:0] addr;
    int       r, kind, guard;
    logic [2:0] ld_f3[5];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
    ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

    rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_funct3_i = 3'd0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_wb_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_wb_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_wb_we", 32'(wb_we_o), 32'd0);
    chk("rst_wb_adr", wb_adr_o, 32'd0);
    chk("rst_wb_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_wb_dat", wb_dat_o, 32'd0);
    rst_ni = 1'b1;

    // directed cases
    issue(0, 3'b000, 32'h103, 32'd0, 0, 0, 32'h80FF_1234, 0);  // LB
    issue(0, 3'b101, 32'h102, 32'd0, 0, 0, 32'h8001_0000, 0);  // LHU
    issue(0, 3'b001, 32'h102, 32'd0, 0, 1, 32'h8001_0000, 0);  // LH
    issue(1, 3'b000, 32'h201, 32'hAB, 0, 0, 32'd0, 0);         // SB
    issue(1, 3'b001, 32'h202, 32'h1234, 0, 2, 32'd0, 0);       // SH
    issue(1, 3'b010, 32'h204, 32'hDEAD_BEEF, 0, 0, 32'd0, 0);  // SW
    issue(0, 3'b010, 32'h106, 32'd0, 0, 0, 32'd0, 0);          // misaligned LW
    issue(0, 3'b011, 32'h100, 32'd0, 0, 0, 32'd0, 0);          // illegal funct3
    issue(1, 3'b100, 32'h100, 32'd0, 0, 0, 32'd0, 0);          // illegal store funct3
    issue(0, 3'b010, 32'h100, 32'd0, 3, 0, 32'h1111_2222, 0);  // timeout
    issue(0, 3'b010, 32'h100, 32'd0, 2, 1, 32'h3333_4444, 0);  // ack+err
    issue(1, 3'b010, 32'h300, 32'h5555_6666, 1, 3, 32'd0, 0);  // bus error

    // reset during BUS: no response expected
    issue(0, 3'b010, 32'h400, 32'd0, 3, 0, 32'd0, 1);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("abort_wb_cyc", 32'(wb_cyc_o), 32'd0);
    chk("abort_wb_stb", 32'(wb_stb_o), 32'd0);
    chk("abort_ready", 32'(req_ready_o), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_f3[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      r = $urandom_range(0, 9);
      kind = (r <= 6) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : 3;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(we, f3, addr, $urandom, kind, $urandom_range(0, TMO - 1), $urandom, 0);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("plan_queue_drained", 32'(plan_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the core's memory stage and the Wishbone-style data bus. It accepts one load or store request at a time and checks alignment and funct3 legality. It drives a single bus transaction with byte-lane selects, then returns load data that is byte/half extracted and sign- or zero-extended per funct3. Errors (misalignment, illegal funct3, bus error, timeout) are reported instead of data.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in BUS before the access is aborted with error; legal range 1..65535.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  1  core presents a request.
- req_ready_o  out  1  controller accepts a request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32 load/store funct3.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data; the low bits are significant.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  completion is an error; valid only with rsp_valid_o.
- wb_cyc_o, wb_stb_o  out  1  bus cycle/strobe.
- wb_we_o  out  1  bus write.
- wb_adr_o  out  32  word address; bits [1:0] are always 0.
- wb_sel_o  out  4  byte-lane enables.
- wb_dat_o  out  32  write data, lane-replicated.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1  bus completion / bus error.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready_o=1. A handshake occurs when req_valid_i=1 in this state. On handshake the controller latches we, funct3, addr and wdata.
- Legality check:
  - Load funct3 must be one of 000, 001, 010, 100, 101.
  - Store funct3 must be one of 000, 001, 010.
  - Half accesses (001, 101) require addr[0]=0.
  - Word accesses (010) require addr[1:0]=0.
- Illegal or misaligned request: go to RESP with error; no bus cycle is issued.
- Legal request: go to BUS.
- BUS: wb_cyc_o=wb_stb_o=1. Address, sel, we and dat are held constant for the whole BUS state. A cycle counter starts at 0.
  - wb_err_i=1: go to RESP with error. Error has priority over ack in the same cycle.
  - wb_ack_i=1: go to RESP without error. On a load, capture the extended data.
  - Otherwise, if the counter equals TIMEOUT-1: go to RESP with error. Ack and err take priority over timeout.
  - Otherwise the counter increments.
- RESP: rsp_valid_o=1 for exactly one cycle, then return to IDLE. req_ready_o=0 in BUS and RESP.
- Store byte lanes:
  - SB: sel = 0001 << addr[1:0]; dat = byte replicated ×4.
  - SH: sel = 0011 << (2·addr[1]); dat = half replicated ×2.
  - SW: sel = 1111; dat = wdata.
- Loads: sel = 1111 for every load width.
- Load extraction:
  - LB/LBU select the byte at addr[1:0].
  - LH/LHU select the half at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes wb_dat_i unchanged.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from input to output.
- Reset values: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_sel_o=0, wb_dat_o=0, counter=0.
- Legal access with zero-wait ack:
  - Handshake at edge N.
  - BUS during cycle N+1, with the ack sampled in that cycle.
  - rsp_valid_o during cycle N+2.
  - Next handshake possible at cycle N+3.
- Each bus wait cycle adds one cycle of latency.
- Illegal or misaligned request: handshake at N, rsp_valid_o with rsp_err_o=1 at N+1.
- Timeout: exactly TIMEOUT cycles in BUS, then RESP with error.
  - wb_cyc_o drops on the same edge as the transition to RESP.
  - A late ack arriving in RESP or IDLE is ignored.
- Reset asserted mid-BUS: on the next edge wb_cyc_o/wb_stb_o=0, state=IDLE, and no rsp_valid_o is generated.
- req_valid_i while busy is not accepted and is not lost; the core holds it until req_ready_o=1.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - The state encoding.
  - A legality function (we, funct3, addr[1:0]) → ok.
- Sub-module lsu_load_align (combinational):
  - Inputs: wb_dat_i, funct3, addr[1:0].
  - Output: 32-bit extended data.
  - Instantiated once; its output is registered into rsp_rdata_o on ack.
- Store lane/sel generation stays inline in lsu_ctrl.

## Test plan
- LB at addr 0x103, wb_dat_i=0x80FF_1234, ack in first BUS cycle → rsp_rdata_o=0xFFFF_FF80, err=0, rsp_valid_o 2 cycles after handshake.
- LHU at 0x102, wb_dat_i=0x8001_0000 → rsp_rdata_o=0x0000_8001; LH at the same address → 0xFFFF_8001.
- SB at 0x201, wdata=0xAB → wb_adr_o=0x200, wb_sel_o=0010, wb_dat_o=0xABAB_ABAB, wb_we_o=1.
- SH at 0x202, wdata=0x1234 → wb_sel_o=1100, wb_dat_o=0x1234_1234.
- LW at 0x106; then load with funct3=011 → rsp_err_o=1 at N+1 in each case, wb_cyc_o never asserted.
- TIMEOUT=4, no ack → wb_cyc_o high exactly 4 cycles, then rsp_err_o=1.
- Ack and err asserted together → rsp_err_o=1.
- rst_ni low during BUS → wb_cyc_o=0 next edge, no rsp_valid_o.
